// File: rtl/fp_unit_arbiter.sv
// ---------------------------------------------------------------------------
// FpUnitArbiter (module fp_unit_arbiter)
//
// Shares a single FpUnit between two requesters. Requester 0 is typically the
// FP issue stage and requester 1 a microcode/CSR helper. The arbiter grants
// round-robin, keeps one operation in flight, and holds the registered
// operands stable for the whole operation, including a multi-cycle sqrt.
// When the FpUnit reports done, the result is buffered and returned to the
// owning requester over a valid/ready channel. A global flush cancels
// whatever is in flight.
//
// Optional feature macro: FP_ARB_WATCHDOG_EN
//   Defined     : BUSY watchdog. After TIMEOUT_CYCLES BUSY cycles without
//                 fpuDone the FpUnit is flushed and an error response
//                 (respError=1, zero results and flags) is returned.
//   Not defined : no counter, respError tied to 0.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   flush               global pipeline flush
//   reqValid/reqReady   per-requester request handshake
//   req*                per-requester unit, command, rounding mode, operands
//   respValid/respReady per-requester response handshake
//   resp*               shared buffered result fields
//   fpu*                FpUnit control/operand outputs and result inputs
// ---------------------------------------------------------------------------
module fp_unit_arbiter #(
  parameter int FP_WIDTH       = 32,
  parameter int CMD_WIDTH      = 8,
  parameter int UNIT_WIDTH     = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,

  input  logic [1:0]                     reqValid,
  output logic [1:0]                     reqReady,
  input  logic [1:0][UNIT_WIDTH-1:0]     reqUnit,
  input  logic [1:0][CMD_WIDTH-1:0]      reqCommand,
  input  logic [1:0][2:0]                reqRoundingMode,
  input  logic [1:0][31:0]               reqIntSrc1,
  input  logic [1:0][31:0]               reqIntSrc2,
  input  logic [1:0][FP_WIDTH-1:0]       reqFpSrc1,
  input  logic [1:0][FP_WIDTH-1:0]       reqFpSrc2,
  input  logic [1:0][FP_WIDTH-1:0]       reqFpSrc3,

  output logic [1:0]                     respValid,
  input  logic [1:0]                     respReady,
  output logic [31:0]                    respIntResult,
  output logic [FP_WIDTH-1:0]            respFpResult,
  output logic                           respFlagsValid,
  output logic [4:0]                     respFlags,
  output logic                           respError,

  output logic                           fpuEnable,
  output logic                           fpuFlush,
  output logic [UNIT_WIDTH-1:0]          fpuUnit,
  output logic [CMD_WIDTH-1:0]           fpuCommand,
  output logic [2:0]                     fpuRoundingMode,
  output logic [31:0]                    fpuIntSrc1,
  output logic [31:0]                    fpuIntSrc2,
  output logic [FP_WIDTH-1:0]            fpuFpSrc1,
  output logic [FP_WIDTH-1:0]            fpuFpSrc2,
  output logic [FP_WIDTH-1:0]            fpuFpSrc3,
  input  logic [31:0]                    fpuIntResult,
  input  logic [FP_WIDTH-1:0]            fpuFpResult,
  input  logic                           fpuWriteFlags,
  input  logic [4:0]                     fpuWriteFlagsValue,
  input  logic                           fpuDone
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic lastGrant_q;
  logic owner_q;

  logic [UNIT_WIDTH-1:0] opUnit_q;
  logic [CMD_WIDTH-1:0]  opCommand_q;
  logic [2:0]            opRoundingMode_q;
  logic [31:0]           opIntSrc1_q;
  logic [31:0]           opIntSrc2_q;
  logic [FP_WIDTH-1:0]   opFpSrc1_q;
  logic [FP_WIDTH-1:0]   opFpSrc2_q;
  logic [FP_WIDTH-1:0]   opFpSrc3_q;

  logic [31:0]           resIntResult_q;
  logic [FP_WIDTH-1:0]   resFpResult_q;
  logic                  resFlagsValid_q;
  logic [4:0]            resFlags_q;

  logic grant;
  logic handshake;
  logic doneAccept;
  logic timeout;

  // A watchdog limit of zero would never let BUSY make progress.
  if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
    $error("fp_unit_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  // Round-robin pick: with both requesters valid, the one that did not win
  // last time gets the grant; otherwise whichever one is valid.
  always_comb begin
    grant = 1'b0;
    if (reqValid == 2'b11) begin
      grant = ~lastGrant_q;
    end else begin
      grant = reqValid[1];
    end
  end

  // Flush takes priority over every other event in the same cycle.
  assign handshake  = (state_q == IDLE) && !flush && reqValid[grant];
  assign doneAccept = (state_q == BUSY) && !flush && fpuDone;

`ifdef FP_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wdCount_q;
  logic            resError_q;

  // Counts completed BUSY cycles; cleared on each accepted request so the
  // limit fires in the TIMEOUT_CYCLES-th BUSY cycle of this operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdCount_q <= '0;
    end else if (handshake) begin
      wdCount_q <= '0;
    end else if (state_q == BUSY) begin
      wdCount_q <= wdCount_q + WD_W'(1);
    end
  end

  assign timeout = (state_q == BUSY) && !flush && !fpuDone &&
                   (wdCount_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resError_q <= 1'b0;
    end else if (doneAccept) begin
      resError_q <= 1'b0;
    end else if (timeout) begin
      resError_q <= 1'b1;
    end
  end

  assign respError = resError_q;
`else
  assign timeout   = 1'b0;
  assign respError = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else if (fpuDone || timeout) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (flush || respReady[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and FpUnit control outputs. respValid is masked by flush so a
  // dropped response can never be seen as consumed.
  always_comb begin
    reqReady  = 2'b00;
    respValid = 2'b00;
    fpuEnable = 1'b0;
    fpuFlush  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!flush && reqValid[grant]) begin
          reqReady[grant] = 1'b1;
        end
      end
      BUSY: begin
        fpuEnable = !flush && !timeout;
        fpuFlush  = flush || timeout;
      end
      RESP: begin
        if (!flush) begin
          respValid[owner_q] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Grant bookkeeping and operand capture on the request handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastGrant_q      <= 1'b1;
      owner_q          <= 1'b0;
      opUnit_q         <= '0;
      opCommand_q      <= '0;
      opRoundingMode_q <= '0;
      opIntSrc1_q      <= '0;
      opIntSrc2_q      <= '0;
      opFpSrc1_q       <= '0;
      opFpSrc2_q       <= '0;
      opFpSrc3_q       <= '0;
    end else if (handshake) begin
      lastGrant_q      <= grant;
      owner_q          <= grant;
      opUnit_q         <= reqUnit[grant];
      opCommand_q      <= reqCommand[grant];
      opRoundingMode_q <= reqRoundingMode[grant];
      opIntSrc1_q      <= reqIntSrc1[grant];
      opIntSrc2_q      <= reqIntSrc2[grant];
      opFpSrc1_q       <= reqFpSrc1[grant];
      opFpSrc2_q       <= reqFpSrc2[grant];
      opFpSrc3_q       <= reqFpSrc3[grant];
    end
  end

  // Result buffer. Flags are stored pre-masked so respFlags is zero whenever
  // respFlagsValid is low. A watchdog abort returns all-zero results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resIntResult_q  <= '0;
      resFpResult_q   <= '0;
      resFlagsValid_q <= 1'b0;
      resFlags_q      <= '0;
    end else if (doneAccept) begin
      resIntResult_q  <= fpuIntResult;
      resFpResult_q   <= fpuFpResult;
      resFlagsValid_q <= fpuWriteFlags;
      resFlags_q      <= fpuWriteFlags ? fpuWriteFlagsValue : 5'b0;
    end else if (timeout) begin
      resIntResult_q  <= '0;
      resFpResult_q   <= '0;
      resFlagsValid_q <= 1'b0;
      resFlags_q      <= '0;
    end
  end

  assign fpuUnit         = opUnit_q;
  assign fpuCommand      = opCommand_q;
  assign fpuRoundingMode = opRoundingMode_q;
  assign fpuIntSrc1      = opIntSrc1_q;
  assign fpuIntSrc2      = opIntSrc2_q;
  assign fpuFpSrc1       = opFpSrc1_q;
  assign fpuFpSrc2       = opFpSrc2_q;
  assign fpuFpSrc3       = opFpSrc3_q;

  assign respIntResult  = resIntResult_q;
  assign respFpResult   = resFpResult_q;
  assign respFlagsValid = resFlagsValid_q;
  assign respFlags      = resFlags_q;

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for fp_unit_arbiter (default build, watchdog disabled).
// A table of single-operation vectors with hand-computed grants and results,
// followed by hand-written sequences for round-robin streaming, flush in
// BUSY, a stalled response with flush in RESP, and asynchronous reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_fp_unit_arbiter;

  localparam int FP_WIDTH   = 32;
  localparam int CMD_WIDTH  = 8;
  localparam int UNIT_WIDTH = 3;

  logic                       clk;
  logic                       rst;
  logic                       flush;
  logic [1:0]                 reqValid;
  logic [1:0]                 reqReady;
  logic [1:0][UNIT_WIDTH-1:0] reqUnit;
  logic [1:0][CMD_WIDTH-1:0]  reqCommand;
  logic [1:0][2:0]            reqRoundingMode;
  logic [1:0][31:0]           reqIntSrc1;
  logic [1:0][31:0]           reqIntSrc2;
  logic [1:0][FP_WIDTH-1:0]   reqFpSrc1;
  logic [1:0][FP_WIDTH-1:0]   reqFpSrc2;
  logic [1:0][FP_WIDTH-1:0]   reqFpSrc3;
  logic [1:0]                 respValid;
  logic [1:0]                 respReady;
  logic [31:0]                respIntResult;
  logic [FP_WIDTH-1:0]        respFpResult;
  logic                       respFlagsValid;
  logic [4:0]                 respFlags;
  logic                       respError;
  logic                       fpuEnable;
  logic                       fpuFlush;
  logic [UNIT_WIDTH-1:0]      fpuUnit;
  logic [CMD_WIDTH-1:0]       fpuCommand;
  logic [2:0]                 fpuRoundingMode;
  logic [31:0]                fpuIntSrc1;
  logic [31:0]                fpuIntSrc2;
  logic [FP_WIDTH-1:0]        fpuFpSrc1;
  logic [FP_WIDTH-1:0]        fpuFpSrc2;
  logic [FP_WIDTH-1:0]        fpuFpSrc3;
  logic [31:0]                fpuIntResult;
  logic [FP_WIDTH-1:0]        fpuFpResult;
  logic                       fpuWriteFlags;
  logic [4:0]                 fpuWriteFlagsValue;
  logic                       fpuDone;

  int testsRun = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  reqValid;
    logic [2:0]  unit;
    logic [31:0] fpSrc1;
    int          doneDelay;
    logic [31:0] fpResult;
    logic [31:0] intResult;
    logic        writeFlags;
    logic [4:0]  flagsValue;
    int          grantExp;
    logic [4:0]  flagsExp;
  } vec_t;

  vec_t vecs[7];

  fp_unit_arbiter #(
    .FP_WIDTH(FP_WIDTH),
    .CMD_WIDTH(CMD_WIDTH),
    .UNIT_WIDTH(UNIT_WIDTH),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .reqValid(reqValid),
    .reqReady(reqReady),
    .reqUnit(reqUnit),
    .reqCommand(reqCommand),
    .reqRoundingMode(reqRoundingMode),
    .reqIntSrc1(reqIntSrc1),
    .reqIntSrc2(reqIntSrc2),
    .reqFpSrc1(reqFpSrc1),
    .reqFpSrc2(reqFpSrc2),
    .reqFpSrc3(reqFpSrc3),
    .respValid(respValid),
    .respReady(respReady),
    .respIntResult(respIntResult),
    .respFpResult(respFpResult),
    .respFlagsValid(respFlagsValid),
    .respFlags(respFlags),
    .respError(respError),
    .fpuEnable(fpuEnable),
    .fpuFlush(fpuFlush),
    .fpuUnit(fpuUnit),
    .fpuCommand(fpuCommand),
    .fpuRoundingMode(fpuRoundingMode),
    .fpuIntSrc1(fpuIntSrc1),
    .fpuIntSrc2(fpuIntSrc2),
    .fpuFpSrc1(fpuFpSrc1),
    .fpuFpSrc2(fpuFpSrc2),
    .fpuFpSrc3(fpuFpSrc3),
    .fpuIntResult(fpuIntResult),
    .fpuFpResult(fpuFpResult),
    .fpuWriteFlags(fpuWriteFlags),
    .fpuWriteFlagsValue(fpuWriteFlagsValue),
    .fpuDone(fpuDone)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    flush              = 1'b0;
    reqValid           = 2'b00;
    respReady          = 2'b00;
    reqUnit            = '0;
    reqCommand         = '0;
    reqRoundingMode    = '0;
    reqIntSrc1         = '0;
    reqIntSrc2         = '0;
    reqFpSrc1          = '0;
    reqFpSrc2          = '0;
    reqFpSrc3          = '0;
    fpuIntResult       = '0;
    fpuFpResult        = '0;
    fpuWriteFlags      = 1'b0;
    fpuWriteFlagsValue = '0;
    fpuDone            = 1'b0;
  endtask

  // Holds reset over a falling edge, optionally checking the reset state.
  task automatic doReset(input bit check);
    idleInputs();
    rst = 1'b0;
    @(negedge clk);
    if (check) begin
      checkOutput("rst_reqReady", 64'(reqReady), 64'h0);
      checkOutput("rst_respValid", 64'(respValid), 64'h0);
      checkOutput("rst_fpuEnable", 64'(fpuEnable), 64'h0);
      checkOutput("rst_fpuFlush", 64'(fpuFlush), 64'h0);
      checkOutput("rst_fpuFpSrc1", 64'(fpuFpSrc1), 64'h0);
      checkOutput("rst_fpuUnit", 64'(fpuUnit), 64'h0);
      checkOutput("rst_respFpResult", 64'(respFpResult), 64'h0);
      checkOutput("rst_respFlagsValid", 64'(respFlagsValid), 64'h0);
      checkOutput("rst_respFlags", 64'(respFlags), 64'h0);
      checkOutput("rst_respError", 64'(respError), 64'h0);
    end
    nextCycle();
    rst = 1'b1;
  endtask

  // Drives both request channels; requester 1 gets inverted operands so a
  // wrong operand mux select is visible on fpuFpSrc1/fpuUnit.
  task automatic applyStimulus(input vec_t v);
    reqValid        = v.reqValid;
    reqUnit[0]      = v.unit;
    reqUnit[1]      = ~v.unit;
    reqFpSrc1[0]    = v.fpSrc1;
    reqFpSrc1[1]    = ~v.fpSrc1;
    reqFpSrc2[0]    = 32'h4000_0000;
    reqFpSrc2[1]    = 32'h4040_0000;
    reqFpSrc3       = '0;
    reqIntSrc1[0]   = 32'h0000_0011;
    reqIntSrc1[1]   = 32'h0000_0022;
  endtask

  task automatic runVector(input int idx, input vec_t v);
    logic [31:0] expSrc1;
    logic [2:0]  expUnit;
    logic [31:0] expInt1;
    expSrc1 = (v.grantExp == 1) ? ~v.fpSrc1 : v.fpSrc1;
    expUnit = (v.grantExp == 1) ? ~v.unit : v.unit;
    expInt1 = (v.grantExp == 1) ? 32'h22 : 32'h11;

    applyStimulus(v);
    @(negedge clk);
    checkOutput($sformatf("v%0d_reqReady", idx), 64'(reqReady), 64'(2'b01 << v.grantExp));
    nextCycle();
    reqValid  = 2'b00;
    reqFpSrc1 = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
    reqUnit   = '0;

    for (int d = 0; d <= v.doneDelay; d++) begin
      fpuDone            = (d == v.doneDelay);
      fpuFpResult        = v.fpResult;
      fpuIntResult       = v.intResult;
      fpuWriteFlags      = v.writeFlags;
      fpuWriteFlagsValue = v.flagsValue;
      @(negedge clk);
      checkOutput($sformatf("v%0d_busy%0d_fpuEnable", idx, d), 64'(fpuEnable), 64'h1);
      checkOutput($sformatf("v%0d_busy%0d_fpuFpSrc1", idx, d), 64'(fpuFpSrc1), 64'(expSrc1));
      checkOutput($sformatf("v%0d_busy%0d_respValid", idx, d), 64'(respValid), 64'h0);
      if (d == 0) begin
        checkOutput($sformatf("v%0d_fpuUnit", idx), 64'(fpuUnit), 64'(expUnit));
        checkOutput($sformatf("v%0d_fpuIntSrc1", idx), 64'(fpuIntSrc1), 64'(expInt1));
      end
      nextCycle();
    end

    // FpUnit outputs go to garbage: the response must come from the buffer.
    fpuDone            = 1'b0;
    fpuFpResult        = 32'h0BAD_0BAD;
    fpuIntResult       = 32'h0BAD_0BAD;
    fpuWriteFlags      = 1'b1;
    fpuWriteFlagsValue = 5'h1F;
    respReady          = 2'b01 << v.grantExp;
    @(negedge clk);
    checkOutput($sformatf("v%0d_respValid", idx), 64'(respValid), 64'(2'b01 << v.grantExp));
    checkOutput($sformatf("v%0d_respFpResult", idx), 64'(respFpResult), 64'(v.fpResult));
    checkOutput($sformatf("v%0d_respIntResult", idx), 64'(respIntResult), 64'(v.intResult));
    checkOutput($sformatf("v%0d_respFlagsValid", idx), 64'(respFlagsValid), 64'(v.writeFlags));
    checkOutput($sformatf("v%0d_respFlags", idx), 64'(respFlags), 64'(v.flagsExp));
    checkOutput($sformatf("v%0d_respError", idx), 64'(respError), 64'h0);
    checkOutput($sformatf("v%0d_resp_fpuEnable", idx), 64'(fpuEnable), 64'h0);
    nextCycle();
    respReady     = 2'b00;
    fpuWriteFlags = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("v%0d_after_respValid", idx), 64'(respValid), 64'h0);
    nextCycle();
  endtask

  initial begin
    int         order[4];
    int         nGrants;
    bit         bothSeen;

    // Grants assume lastGrant=1 after reset and follow the history above.
    vecs[0] = '{2'b01, 3'd0, 32'h3F80_0000, 0,  32'h4000_0000, 32'h0,         1'b1, 5'h00, 0, 5'h00};
    vecs[1] = '{2'b11, 3'd2, 32'h4080_0000, 3,  32'h4000_0000, 32'h0,         1'b1, 5'h01, 1, 5'h01};
    vecs[2] = '{2'b11, 3'd1, 32'h4120_0000, 1,  32'h0,         32'h0000_000A, 1'b0, 5'h1F, 0, 5'h00};
    vecs[3] = '{2'b10, 3'd0, 32'hBF80_0000, 0,  32'hC000_0000, 32'h0,         1'b1, 5'h10, 1, 5'h10};
    vecs[4] = '{2'b10, 3'd3, 32'h3F00_0000, 2,  32'h3F80_0000, 32'hFFFF_FFFF, 1'b1, 5'h03, 1, 5'h03};
    vecs[5] = '{2'b01, 3'd2, 32'h4180_0000, 19, 32'h4080_0000, 32'h0,         1'b1, 5'h01, 0, 5'h01};
    vecs[6] = '{2'b11, 3'd4, 32'h0000_0000, 0,  32'h7FC0_0000, 32'h0,         1'b1, 5'h10, 1, 5'h10};

    doReset(1'b1);
    for (int i = 0; i < 7; i++) begin
      runVector(i, vecs[i]);
    end

    // Round-robin streaming: both valid, immediate done and response consume.
    doReset(1'b0);
    reqValid  = 2'b11;
    respReady = 2'b11;
    fpuDone   = 1'b1;
    nGrants   = 0;
    bothSeen  = 1'b0;
    for (int i = 0; i < 4; i++) order[i] = -1;
    for (int c = 0; c < 40 && nGrants < 4; c++) begin
      @(negedge clk);
      if (reqReady == 2'b11) bothSeen = 1'b1;
      if (reqReady != 2'b00) begin
        order[nGrants] = int'(reqReady[1]);
        nGrants++;
      end
      nextCycle();
    end
    checkOutput("rr_bothReady", 64'(bothSeen), 64'h0);
    checkOutput("rr_grantCount", 64'(nGrants), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr_grant%0d", i), 64'(order[i]), 64'(i % 2));
    end
    reqValid = 2'b00;
    for (int c = 0; c < 4; c++) nextCycle();
    fpuDone   = 1'b0;
    respReady = 2'b00;
    nextCycle();

    // Flush in the 3rd BUSY cycle, same cycle as fpuDone: flush wins.
    reqValid     = 2'b01;
    reqFpSrc1[0] = 32'h4100_0000;
    @(negedge clk);
    checkOutput("fl_reqReady", 64'(reqReady), 64'h1);
    nextCycle();
    reqValid = 2'b00;
    nextCycle();
    nextCycle();
    flush   = 1'b1;
    fpuDone = 1'b1;
    @(negedge clk);
    checkOutput("fl_fpuFlush", 64'(fpuFlush), 64'h1);
    checkOutput("fl_fpuEnable", 64'(fpuEnable), 64'h0);
    checkOutput("fl_respValid", 64'(respValid), 64'h0);
    nextCycle();
    flush        = 1'b0;
    fpuDone      = 1'b0;
    reqValid     = 2'b10;
    reqFpSrc1[1] = 32'h4200_0000;
    @(negedge clk);
    checkOutput("fl_after_fpuFlush", 64'(fpuFlush), 64'h0);
    checkOutput("fl_after_respValid", 64'(respValid), 64'h0);
    checkOutput("fl_next_reqReady", 64'(reqReady), 64'h2);
    nextCycle();
    reqValid    = 2'b00;
    fpuDone     = 1'b1;
    fpuFpResult = 32'h1234_5678;
    nextCycle();

    // Stalled response with both requesters valid, then flush in RESP.
    fpuDone     = 1'b0;
    fpuFpResult = 32'h0;
    reqValid    = 2'b11;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("st%0d_respValid", c), 64'(respValid), 64'h2);
      checkOutput($sformatf("st%0d_respFpResult", c), 64'(respFpResult), 64'h1234_5678);
      checkOutput($sformatf("st%0d_reqReady", c), 64'(reqReady), 64'h0);
      nextCycle();
    end
    flush = 1'b1;
    @(negedge clk);
    checkOutput("stfl_respValid", 64'(respValid), 64'h0);
    checkOutput("stfl_reqReady", 64'(reqReady), 64'h0);
    nextCycle();
    flush = 1'b0;
    @(negedge clk);
    checkOutput("stfl_idle_respValid", 64'(respValid), 64'h0);
    checkOutput("stfl_idle_reqReady", 64'(reqReady), 64'h1);
    nextCycle();
    reqValid    = 2'b00;
    fpuDone     = 1'b1;
    fpuFpResult = 32'h3F80_0000;
    nextCycle();
    fpuDone   = 1'b0;
    respReady = 2'b11;
    @(negedge clk);
    checkOutput("stfl_last_respValid", 64'(respValid), 64'h1);
    checkOutput("stfl_last_respFpResult", 64'(respFpResult), 64'h3F80_0000);
    nextCycle();
    respReady = 2'b00;

    // Asynchronous reset in the middle of BUSY clears state without a clock.
    reqValid     = 2'b01;
    reqFpSrc1[0] = 32'h4040_0000;
    nextCycle();
    reqValid = 2'b00;
    @(negedge clk);
    checkOutput("ar_busy_fpuEnable", 64'(fpuEnable), 64'h1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("ar_fpuEnable", 64'(fpuEnable), 64'h0);
    checkOutput("ar_fpuFpSrc1", 64'(fpuFpSrc1), 64'h0);
    nextCycle();
    rst = 1'b1;
    nextCycle();

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
